// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// Instruction-fetch stage with the IF/ID pipeline register.
//
// Holds the program counter, issues fetch requests to instruction memory and
// captures the returned word (with its PC+4) into the IF/ID register for the
// decode stage. Redirects from ID, stalls from the hazard unit and memory
// wait cycles are resolved with a fixed per-cycle priority:
//   rst > branchTaken > stallIF > imemReady=0 > normal advance
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   stallIF        : hold PC this cycle
//   ifIdWrite      : 1 = IF/ID may update, 0 = IF/ID holds its contents
//   branchTaken    : redirect request; load branchTarget (bits [1:0] cleared)
//   branchTarget   : redirect address
//   imemAddr       : fetch address, a direct copy of the PC register
//   imemReq        : fetch request, high in FETCH and WAIT
//   imemReady      : imemData is valid for imemAddr this cycle
//   imemData       : fetched instruction word
//   instrID        : instruction presented to ID
//   pcPlus4ID      : PC+4 of instrID
//   validID        : 1 = instrID is real, 0 = bubble
//   fsmState       : debug view of the fetch FSM state
//
// Memory handshake: a fetch completes in the cycle where imemReq=1 and
// imemReady=1 are both sampled at the rising edge; imemData belongs to
// imemAddr in that cycle. imemAddr is stable while imemReady=0 unless a
// redirect or reset abandons the outstanding fetch.
// -----------------------------------------------------------------------------
module if_id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallIF,
   input  logic        ifIdWrite,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic [31:0] imemAddr,
   output logic        imemReq,
   input  logic        imemReady,
   input  logic [31:0] imemData,
   output logic [31:0] instrID,
   output logic [31:0] pcPlus4ID,
   output logic        validID,
   output logic [1:0]  fsmState
);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic [31:0] pc_plus4;

   // Wraps modulo 2^32 by construction.
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;

      case (state_q)
         S_RESET: begin
            // First cycle out of reset issues no fetch; the PC is already 0.
            state_d = S_FETCH;
         end
         default: begin
            if (branchTaken) begin
               // Redirect abandons any outstanding fetch and flushes IF/ID,
               // regardless of stall or write-enable.
               pc_d    = branchTarget & 32'hFFFF_FFFC;
               instr_d = 32'h0;
               pcp4_d  = 32'h0;
               valid_d = 1'b0;
               state_d = S_FETCH;
            end else begin
               state_d = imemReady ? S_FETCH : S_WAIT;
               if (stallIF || !imemReady) begin
                  // PC held; a bubble is inserted only if IF/ID may update.
                  if (ifIdWrite) begin
                     instr_d = 32'h0;
                     pcp4_d  = 32'h0;
                     valid_d = 1'b0;
                  end
               end else begin
                  pc_d = pc_plus4;
                  if (ifIdWrite) begin
                     instr_d = imemData;
                     pcp4_d  = pc_plus4;
                     valid_d = 1'b1;
                  end
               end
            end
         end
      endcase

      req_d = (state_d != S_RESET);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         pc_q    <= 32'h0;
         instr_q <= 32'h0;
         pcp4_q  <= 32'h0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign imemAddr  = pc_q;
   assign imemReq   = req_q;
   assign instrID   = instr_q;
   assign pcPlus4ID = pcp4_q;
   assign validID   = valid_q;
   assign fsmState  = state_q;

endmodule
